spi_reg_bridge: RTL
===================

# spi_reg_bridge

Parametrised SPI slave register bridge; the next generation of the board's SPI register interface. It receives DATA_W-bit command and data words from the host CPU, then performs auto-incrementing burst reads from a flat register read-back bus or burst writes emitted as one-cycle write strobes. Register storage lives in the consuming logic, not in this block. It sits between the CPU SPI pins and the motor/servo/ADC register logic, all on SYS_CLK.

## Interface
- DATA_W, 16: SPI word width in bits; minimum ADDR_W+2.
- ADDR_W, 10: address field width; the address counter is ADDR_W bits.
- NUM_REGS, 64: number of readable registers on rd_bus.
- WR_BASE, 25: lowest writable address; writable range is WR_BASE..NUM_REGS-1.
- ID_WORD, 16'h4A53: value transmitted during every command word.
- SYS_CLK  in  1  system clock; all logic is clocked on its rising edge.
- SYS_RST  in  1  synchronous, active-high reset.
- SPI_CLK  in  1  asynchronous SPI clock from the host.
- SSEL  in  1  asynchronous slave select, active low.
- MOSI  in  1  asynchronous serial data in, MSB first.
- MISO  out  1  serial data out, MSB first.
- rd_bus  in  NUM_REGS*DATA_W  read-back values; register k is at [k*DATA_W +: DATA_W]. Register 0 is ignored and replaced by ID_WORD.
- wr_strobe  out  1  one-cycle pulse; wr_addr and wr_data are valid while it is high.
- wr_addr  out  ADDR_W  target address of the write.
- wr_data  out  DATA_W  received data word.
- wr_reject  out  1  one-cycle pulse when a write targets a non-writable address.
- frame_err  out  1  one-cycle pulse when SSEL deasserts in the middle of a word.
- busy  out  1  high while a frame is active (SSEL low, synchronised).

## Operation
- Synchronisation: SPI_CLK, SSEL and MOSI each pass through a 3-flop shift register. Edges are detected on the two oldest flops.
- Receive: MOSI is shifted in on each SPI_CLK falling edge. Bit counter is log2(DATA_W) wide and held at 0 while SSEL is inactive. word_done asserts when the last bit of a word is shifted in.
- Transmit: MISO is the MSB of the TX shift register. The register shifts left, filling with 0, on each SPI_CLK rising edge. It is loaded with ID_WORD on the SSEL falling edge.
- Command word: bits [DATA_W-1:DATA_W-2] are the opcode (10 = read, 01 = write, 00/11 = no-op). Bits [ADDR_W-1:0] are the start address (addr).
- States and transitions:
  - IDLE: on SSEL falling edge go to CMD.
  - CMD: on word_done, read -> RD, write -> WR, no-op -> DISCARD.
  - RD: on each word_done, TX is loaded with reg(addr), then addr increments. The first data word carries reg(start address).
  - WR: each word_done writes the word to addr, then addr increments.
  - DISCARD: ignores all traffic and transmits 0.
  - Any state, on SSEL rising edge: go to IDLE.
- RD and the command word: on the CMD->RD transition, TX is loaded with reg(start address) and addr becomes start+1.
- reg(a): ID_WORD if a = 0; rd_bus slice if 0 < a < NUM_REGS; 0 otherwise.
- Write to an address outside WR_BASE..NUM_REGS-1: no strobe, wr_reject pulses, addr still increments.
- addr wraps modulo 2^ADDR_W.
- Aborted word (SSEL rises with bit counter nonzero): partial word discarded, no write, frame_err pulses.
- SYS_RST: state IDLE, addr 0, bit counter 0, TX 0, all outputs 0. If reset lands mid-frame (SSEL already low), the block enters DISCARD at the first detected SPI_CLK edge and stays there until SSEL deasserts.

## Timing
- Host constraint: SPI_CLK high and low phases each at least 4 SYS_CLK cycles. SSEL low to first SPI_CLK edge at least 4 SYS_CLK cycles.
- word_done asserts 3 SYS_CLK cycles after the last SPI_CLK falling edge at the pin.
- TX load for the next word happens 1 cycle after word_done. rd_bus is sampled in that cycle.
- wr_strobe, wr_reject and frame_err assert 1 cycle after their trigger and stay high exactly 1 cycle.
- In a single cycle, a TX load takes priority over a TX shift.
- If SSEL rises in the same cycle as word_done: the word completes (write is issued), then IDLE; no frame_err.

## Test plan
- Reset, with SSEL held high: every output is 0 and MISO is 0. The first frame transmits 16'h4A53 during its command word.
- Read burst: command 16'h8002, then 3 dummy words, with rd_bus reg2=0x0011, reg3=0x0022, reg4=0x03FF -> MISO words are 4A53, 0011, 0022, 03FF. No wr_strobe.
- Write burst: command 16'h4019 (addr 25), then 0x05DC, 0x0640 -> two wr_strobe pulses, at (25,0x05DC) and (26,0x0640).
- Write to a read-only address: command 16'h4005, then 0x1234 -> wr_reject pulses once, no wr_strobe.
- SSEL abort after 7 bits of the second word in a write burst -> frame_err pulses once, no wr_strobe. The next frame works normally.
- Read of the last register: read starting at 63 (NUM_REGS=64) -> words reg63, 0, 0. Read starting at 1023 -> words 0, then ID_WORD (address wraps to 0).

Source files
------------

// File: rtl/spi_reg_bridge_if.sv
// SPI pin bundle between the host CPU (master) and the register bridge (slave).
interface spi_reg_bridge_if;
  logic SPI_CLK;
  logic SSEL;
  logic MOSI;
  logic MISO;

  modport master (
    output SPI_CLK,
    output SSEL,
    output MOSI,
    input  MISO
  );

  modport slave (
    input  SPI_CLK,
    input  SSEL,
    input  MOSI,
    output MISO
  );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI slave register bridge: burst reads from a flat read-back bus, burst writes
// emitted as one-cycle strobes. All logic runs on SYS_CLK; SPI pins are oversampled.
module spi_reg_bridge #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 10,
  parameter int                NUM_REGS = 64,
  parameter int                WR_BASE  = 25,
  parameter logic [DATA_W-1:0] ID_WORD  = 16'h4A53
) (
  input  logic                       SYS_CLK,
  input  logic                       SYS_RST,
  spi_reg_bridge_if.slave            spi,
  input  logic [NUM_REGS*DATA_W-1:0] rd_bus,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic                       wr_reject,
  output logic                       frame_err,
  output logic                       busy
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam int                IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   NREGS_L  = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W:0]   WRBASE_L = (ADDR_W + 1)'(WR_BASE);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_RD      = 3'd2,
    ST_WR      = 3'd3,
    ST_DISCARD = 3'd4
  } state_e;

  logic [1:0]        fill_q;
  logic [2:0]        sclk_q;
  logic [2:0]        ssel_q;
  logic [2:0]        mosi_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] rx_q;
  logic              word_done_q;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] tx_q;
  logic              wr_strobe_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              wr_reject_q;
  logic              frame_err_q;
  logic              busy_q;

  logic              sync_ok_s;
  logic              sclk_rise_s;
  logic              sclk_fall_s;
  logic              ssel_rise_s;
  logic              ssel_fall_s;
  logic              ssel_act_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [DATA_W-1:0] rd_word_s;
  logic              wr_ok_s;
  logic [DATA_W-1:0] regs_s [NUM_REGS];

  // Edges are only trusted once every synchroniser flop holds a real pin sample,
  // so a reset landing mid-frame never fabricates an SSEL falling edge.
  assign sync_ok_s   = (fill_q == 2'd3);
  assign sclk_rise_s = sync_ok_s & ~sclk_q[2] &  sclk_q[1];
  assign sclk_fall_s = sync_ok_s &  sclk_q[2] & ~sclk_q[1];
  assign ssel_rise_s = sync_ok_s & ~ssel_q[2] &  ssel_q[1];
  assign ssel_fall_s = sync_ok_s &  ssel_q[2] & ~ssel_q[1];
  assign ssel_act_s  = sync_ok_s & ~ssel_q[1];

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
    assign regs_s[k] = rd_bus[k*DATA_W +: DATA_W];
  end

  assign rd_addr_s = (state_q == ST_CMD) ? rx_q[ADDR_W-1:0] : addr_q;
  assign wr_ok_s   = ({1'b0, addr_q} >= WRBASE_L) && ({1'b0, addr_q} < NREGS_L);

  // Read-back mux: address 0 is the ID word, out-of-range addresses read as zero
  always_comb begin
    rd_word_s = {DATA_W{1'b0}};
    if (rd_addr_s == {ADDR_W{1'b0}}) begin
      rd_word_s = ID_WORD;
    end else if ({1'b0, rd_addr_s} < NREGS_L) begin
      rd_word_s = regs_s[rd_addr_s[IDX_W-1:0]];
    end else begin
      rd_word_s = {DATA_W{1'b0}};
    end
  end

  // Pin synchronisers, bit counter and MOSI receive shifter
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      fill_q      <= 2'd0;
      sclk_q      <= 3'b000;
      ssel_q      <= 3'b000;
      mosi_q      <= 3'b000;
      bit_cnt_q   <= CNT_ZERO;
      rx_q        <= {DATA_W{1'b0}};
      word_done_q <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[1:0], spi.SPI_CLK};
      ssel_q      <= {ssel_q[1:0], spi.SSEL};
      mosi_q      <= {mosi_q[1:0], spi.MOSI};
      word_done_q <= 1'b0;
      if (!sync_ok_s) begin
        fill_q <= fill_q + 2'd1;
      end
      if (!ssel_act_s) begin
        bit_cnt_q <= CNT_ZERO;
      end else if (sclk_fall_s) begin
        rx_q <= {rx_q[DATA_W-2:0], mosi_q[2]};
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_q   <= CNT_ZERO;
          word_done_q <= 1'b1;
        end else begin
          bit_cnt_q <= bit_cnt_q + CNT_ONE;
        end
      end
    end
  end

  // Frame FSM with address counter, TX shifter and registered output pulses
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state_q     <= ST_IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      tx_q        <= {DATA_W{1'b0}};
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= {ADDR_W{1'b0}};
      wr_data_q   <= {DATA_W{1'b0}};
      wr_reject_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wr_strobe_q <= 1'b0;
      wr_reject_q <= 1'b0;
      frame_err_q <= ssel_rise_s && (bit_cnt_q != CNT_ZERO);
      busy_q      <= ssel_act_s;
      if (sclk_rise_s) begin
        tx_q <= {tx_q[DATA_W-2:0], 1'b0};
      end
      // Loads below are written after the shift so they win in the same cycle
      case (state_q)
        ST_IDLE: begin
          if (ssel_fall_s) begin
            state_q <= ST_CMD;
            tx_q    <= ID_WORD;
          end else if (ssel_act_s && (sclk_rise_s || sclk_fall_s)) begin
            state_q <= ST_DISCARD;
            tx_q    <= {DATA_W{1'b0}};
          end
        end
        ST_CMD: begin
          if (word_done_q) begin
            case (rx_q[DATA_W-1 -: 2])
              2'b10: begin
                state_q <= ST_RD;
                tx_q    <= rd_word_s;
                addr_q  <= rd_addr_s + ADDR_ONE;
              end
              2'b01: begin
                state_q <= ST_WR;
                addr_q  <= rd_addr_s;
              end
              default: begin
                state_q <= ST_DISCARD;
                tx_q    <= {DATA_W{1'b0}};
              end
            endcase
          end
        end
        ST_RD: begin
          if (word_done_q) begin
            tx_q   <= rd_word_s;
            addr_q <= addr_q + ADDR_ONE;
          end
        end
        ST_WR: begin
          if (word_done_q) begin
            if (wr_ok_s) begin
              wr_strobe_q <= 1'b1;
              wr_addr_q   <= addr_q;
              wr_data_q   <= rx_q;
            end else begin
              wr_reject_q <= 1'b1;
            end
            addr_q <= addr_q + ADDR_ONE;
          end
        end
        ST_DISCARD: begin
          tx_q <= {DATA_W{1'b0}};
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      if (ssel_rise_s) begin
        state_q <= ST_IDLE;
      end
    end
  end

  assign spi.MISO  = tx_q[DATA_W-1];
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_reject = wr_reject_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule
